triangle_sequencer: RTL

TRIANGLE_SEQUENCER -- requirements
Module: triangle_sequencer

---
 rtl/triangle_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/triangle_sequencer.sv
// Queued triangle-wave note player: notes (step, amplitude, duration) are buffered
// in a small FIFO and rendered as signed PCM, one update per prescaler strobe.
module triangle_sequencer #(
    parameter int unsigned C_pcm_bits   = 12,
    parameter int unsigned C_delay      = 10,
    parameter int unsigned C_gap        = 4,
    parameter int unsigned C_fifo_depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         note_valid,
    output logic                         note_ready,
    input  logic [7:0]                   note_step,
    input  logic [C_pcm_bits-2:0]        note_amplitude,
    input  logic [15:0]                  note_duration,
    input  logic                         stop,
    output logic signed [C_pcm_bits-1:0] pcm,
    output logic                         busy,
    output logic                         note_done
);
    localparam int unsigned AMP_W = C_pcm_bits - 1;
    localparam int unsigned SUM_W = C_pcm_bits + 2;
    localparam int unsigned ENT_W = 8 + AMP_W + 16;
    localparam int unsigned PTR_W = (C_fifo_depth > 1) ? $clog2(C_fifo_depth) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = (C_gap > 0) ? $clog2(C_gap + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    // Free-running sample prescaler
    logic [C_delay-1:0] presc;
    logic               strobe;
    assign strobe = &presc;

    logic [ENT_W-1:0] fifo_mem [C_fifo_depth];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt, cnt_next;
    logic             push, pop, fifo_empty;
    logic [ENT_W-1:0] head;
    logic [7:0]       head_step;
    logic [AMP_W-1:0] head_amp;
    logic [15:0]      head_dur;

    assign push       = note_valid && note_ready && !stop;
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_mem[rd_ptr];
    assign head_step  = head[ENT_W-1 -: 8];
    assign head_amp   = head[16 +: AMP_W];
    assign head_dur   = head[15:0];
    assign cnt_next   = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {note_step, note_amplitude, note_duration};
    end

    // Queue pointers; stop flushes the queue and drops a same-clock push
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            note_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt   <= cnt_next;
            note_ready <= (cnt_next != CNT_W'(C_fifo_depth));
        end
    end

    state_t                  state, state_next;
    logic signed [C_pcm_bits-1:0] pcm_next;
    logic                    dir_up, dir_up_next;
    logic [15:0]             rem, rem_next;
    logic [7:0]              step_q, step_next;
    logic [AMP_W-1:0]        amp_q, amp_next;
    logic [GAP_W-1:0]        gap_cnt, gap_next;
    logic                    done_next, load, finish;

    logic signed [SUM_W-1:0] pcm_ext, step_ext, amp_pos, amp_neg, sum_up, sum_dn;
    assign pcm_ext  = {{2{pcm[C_pcm_bits-1]}}, pcm};
    assign step_ext = {{(SUM_W-8){1'b0}}, step_q};
    assign amp_pos  = {3'b000, amp_q};
    assign amp_neg  = -amp_pos;
    assign sum_up   = pcm_ext + step_ext;
    assign sum_dn   = pcm_ext - step_ext;

    // Next-state and datapath; a note ends on the strobe after its last pcm update
    always_comb begin
        state_next  = state;
        pcm_next    = pcm;
        dir_up_next = dir_up;
        rem_next    = rem;
        step_next   = step_q;
        amp_next    = amp_q;
        gap_next    = gap_cnt;
        done_next   = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;
        finish      = 1'b0;
        if (stop) begin
            state_next = S_IDLE;
            pcm_next   = '0;
            done_next  = (state == S_PLAY);
        end else if (strobe) begin
            case (state)
                S_IDLE: load = !fifo_empty;
                S_PLAY: begin
                    if (rem == 16'd0) begin
                        pcm_next  = '0;
                        done_next = 1'b1;
                        if (C_gap == 0) begin
                            finish = 1'b1;
                        end else begin
                            gap_next   = GAP_W'(C_gap);
                            state_next = S_GAP;
                        end
                    end else begin
                        if (dir_up) begin
                            if (sum_up >= amp_pos) begin
                                pcm_next    = amp_pos[C_pcm_bits-1:0];
                                dir_up_next = 1'b0;
                            end else begin
                                pcm_next = sum_up[C_pcm_bits-1:0];
                            end
                        end else begin
                            if (sum_dn <= amp_neg) begin
                                pcm_next    = amp_neg[C_pcm_bits-1:0];
                                dir_up_next = 1'b1;
                            end else begin
                                pcm_next = sum_dn[C_pcm_bits-1:0];
                            end
                        end
                        rem_next = rem - 16'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) finish = 1'b1;
                    else gap_next = gap_cnt - GAP_W'(1);
                end
                default: state_next = S_IDLE;
            endcase
            if (finish) begin
                state_next = S_IDLE;
                load       = !fifo_empty;
            end
            if (load) begin
                pop         = 1'b1;
                step_next   = head_step;
                amp_next    = head_amp;
                rem_next    = (head_dur == 16'd0) ? 16'd1 : head_dur;
                pcm_next    = '0;
                dir_up_next = 1'b1;
                state_next  = S_PLAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            presc     <= '0;
            pcm       <= '0;
            dir_up    <= 1'b1;
            rem       <= '0;
            step_q    <= '0;
            amp_q     <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            note_done <= 1'b0;
        end else begin
            state     <= state_next;
            presc     <= presc + C_delay'(1);
            pcm       <= pcm_next;
            dir_up    <= dir_up_next;
            rem       <= rem_next;
            step_q    <= step_next;
            amp_q     <= amp_next;
            gap_cnt   <= gap_next;
            busy      <= (state_next != S_IDLE);
            note_done <= done_next;
        end
    end

endmodule
